fp_operand_skid_stage: RTL and testbench
========================================

# fp_operand_skid_stage

Parametrised operand register stage for the FP adder pipeline front end. It captures operand A, operand B, the add/subtract select and a caller tag behind a valid/ready handshake, and presents them to the adder datapath. A 2-entry skid buffer sustains one operation per cycle under downstream back-pressure without dropping data. A synchronous flush discards in-flight operations.

## Interface
Parameters:
- WIDTH, 32, operand width in bits (32 = single precision, 64 = double).
- TAG_W, 4, width of the pass-through tag; minimum 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears all state.
- flush  input  1  synchronous, active-high; discards buffered operations.
- in_valid  input  1  upstream holds a valid operation.
- in_ready  output  1  stage accepts an operation this cycle.
- A_in  input  WIDTH  operand A.
- B_in  input  WIDTH  operand B.
- A_S_in  input  1  0 = add, 1 = subtract.
- tag_in  input  TAG_W  caller tag, returned unchanged.
- out_valid  output  1  A_out/B_out/A_S_out/tag_out are valid.
- out_ready  input  1  adder datapath consumes the operation this cycle.
- A_out  output  WIDTH  registered operand A.
- B_out  output  WIDTH  registered operand B.
- A_S_out  output  1  registered add/sub select.
- tag_out  output  TAG_W  registered tag.

## Operation
- Storage: a main register (drives the outputs) and a skid register, each holding {A, B, A_S, tag}.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- State machine (2-bit state register):
  - EMPTY: out_valid=0, in_ready=1. On in_fire, load main and go to BUSY.
  - BUSY: out_valid=1, in_ready=1.
    - in_fire & out_fire: load main with the input; stay in BUSY.
    - in_fire only: load skid; go to FULL.
    - out_fire only: go to EMPTY.
    - Neither: hold.
  - FULL: out_valid=1, in_ready=0. On out_fire, main <= skid and go to BUSY. Input is ignored because in_ready=0.
- in_ready and out_valid are pure decodes of the state register, with no combinational path from in_valid or out_ready.
- Ordering is strict FIFO; tags leave in acceptance order.
- Priority is reset > flush > handshake.
- Reset: state goes to EMPTY; main and skid data registers are cleared to 0.
- Flush: state goes to EMPTY; data registers hold their values; any in_fire or out_fire in the same cycle is void and nothing is loaded.
- While out_valid=1, main contents stay stable until out_fire.
- in_valid in EMPTY/BUSY and in_valid while in_ready=0 carry no upstream obligation; the stage never samples data when in_ready=0.

## Timing
- Reset values: out_valid=0, in_ready=1, A_out=0, B_out=0, A_S_out=0, tag_out=0. These hold from the first edge with reset high.
- Latency: an operation accepted on edge N appears at the output (out_valid=1) after edge N, which is 1 cycle.
- Throughput: 1 op/cycle with out_ready held high. The stage reaches FULL only after back-pressure.
- Back-pressure: after the first cycle with out_ready=0 and in_fire, in_ready drops on the next cycle. At most 2 operations are buffered.
- Recovery from FULL: one out_fire sets in_ready=1 on the following cycle.
- Reset or flush mid-operation takes effect at that edge. On the next cycle out_valid=0 and in_ready=1.

## Test plan
- Reset: assert reset 2 cycles with random inputs -> out_valid=0, in_ready=1, A_out=B_out=0, tag_out=0 on every cycle after the first reset edge.
- Streaming: 8 back-to-back ops (A=0x3F800000+i, B=0x40000000, A_S=i[0], tag=i) with out_ready=1 -> outputs appear 1 cycle later, in order, with no bubbles.
- Back-pressure: tags 1,2,3 offered while out_ready=0 -> tags 1 and 2 accepted, in_ready=0 on cycle 3, tag_out stays 1. Then raise out_ready -> tags 1, 2, 3 emerge in order with nothing lost or duplicated.
- Simultaneous in/out in BUSY: tag 5 at the output with out_ready=1 while tag 6 is offered -> next cycle tag_out=6 and state stays BUSY (in_ready=1).
- Flush in FULL with in_valid=1: tags 7 and 8 buffered -> next cycle out_valid=0, in_ready=1. A fresh tag 9 is then the first to emerge.
- WIDTH=64, TAG_W=1: repeat the streaming test with A=0x3FF0000000000000 -> all 64 bits pass through intact.

Source files
------------

// File: rtl/fp_operand_skid_stage_if.sv
// Operand handshake bundle for the FP adder front-end register stage.
// The master drives operations in and consumes them out; the slave is the stage itself.
interface fp_operand_skid_stage_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A_in;
    logic [WIDTH-1:0] B_in;
    logic             A_S_in;
    logic [TAG_W-1:0] tag_in;

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] A_out;
    logic [WIDTH-1:0] B_out;
    logic             A_S_out;
    logic [TAG_W-1:0] tag_out;

    modport master (
        output in_valid, A_in, B_in, A_S_in, tag_in, out_ready,
        input  in_ready, out_valid, A_out, B_out, A_S_out, tag_out
    );

    modport slave (
        input  in_valid, A_in, B_in, A_S_in, tag_in, out_ready,
        output in_ready, out_valid, A_out, B_out, A_S_out, tag_out
    );
endinterface

// File: rtl/fp_operand_skid_stage.sv
// Registered operand stage with a 2-entry skid buffer feeding the FP adder datapath.
// Handshake outputs decode straight from the state register so no ready/valid path is combinational.
module fp_operand_skid_stage #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    fp_operand_skid_stage_if.slave bus
);
    localparam int DW = 2 * WIDTH + 1 + TAG_W;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [DW-1:0]   main_q;
    logic [DW-1:0]   skid_q;
    logic [DW-1:0]   in_word;
    logic            in_ready_int;
    logic            out_valid_int;
    logic            in_fire;
    logic            out_fire;
    logic            load_main_in;
    logic            load_main_skid;
    logic            load_skid;

    assign in_ready_int  = (state_q == EMPTY) || (state_q == BUSY);
    assign out_valid_int = (state_q == BUSY) || (state_q == FULL);

    assign in_fire  = bus.in_valid & in_ready_int;
    assign out_fire = out_valid_int & bus.out_ready;

    assign in_word = {bus.A_in, bus.B_in, bus.A_S_in, bus.tag_in};

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = out_valid_int;
    assign {bus.A_out, bus.B_out, bus.A_S_out, bus.tag_out} = main_q;

    // Flush voids both handshakes, so no load strobe may fire in that cycle.
    always_comb begin
        state_d        = state_q;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        load_main_in = 1'b1;
                        state_d      = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire) begin
                        load_skid = 1'b1;
                        state_d   = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        load_main_skid = 1'b1;
                        state_d        = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_main_in) begin
                main_q <= in_word;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_word;
            end
        end
    end
endmodule

// File: tb/tb_fp_operand_skid_stage.sv
// Self-checking bench: a FIFO-of-depth-2 queue model checks the 32-bit stage,
// and a direct one-cycle-delay expectation checks a 64-bit / 1-bit-tag instance.
module tb_fp_operand_skid_stage;
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [3:0]  tag;
    } op32_t;

    logic clk;
    logic reset;
    logic flush;

    int checks = 0;
    int errors = 0;

    // Reference model: operations held by the stage, oldest first; shown is what the outputs display.
    op32_t q[$];
    op32_t shown;

    fp_operand_skid_stage_if #(.WIDTH(32), .TAG_W(4)) ifc32 ();
    fp_operand_skid_stage_if #(.WIDTH(64), .TAG_W(1)) ifc64 ();

    fp_operand_skid_stage #(.WIDTH(32), .TAG_W(4)) dut32 (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (ifc32)
    );

    fp_operand_skid_stage #(.WIDTH(64), .TAG_W(1)) dut64 (
        .clk  (clk),
        .reset(reset),
        .flush(flush),
        .bus  (ifc64)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic op32_t rand_op(input logic [3:0] tag);
        op32_t op;
        op.a   = $urandom;
        op.b   = $urandom;
        op.sub = 1'($urandom);
        op.tag = tag;
        return op;
    endfunction

    function automatic logic [70:0] dut_view();
        return {ifc32.out_valid, ifc32.in_ready, ifc32.A_out, ifc32.B_out, ifc32.A_S_out, ifc32.tag_out};
    endfunction

    function automatic logic [70:0] model_view();
        return {q.size() != 0, q.size() < 2, shown};
    endfunction

    // One clock of the 32-bit stage: drive, advance the model, then sample 1 time unit after the edge.
    task automatic applyStimulus(input bit iv, input op32_t op, input bit ordy, input bit fl);
        bit acc;
        bit pop;
        ifc32.in_valid  = iv;
        ifc32.A_in      = op.a;
        ifc32.B_in      = op.b;
        ifc32.A_S_in    = op.sub;
        ifc32.tag_in    = op.tag;
        ifc32.out_ready = ordy;
        flush           = fl;
        acc = iv && (q.size() < 2) && !fl;
        pop = (q.size() > 0) && ordy && !fl;
        if (fl) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (acc) q.push_back(op);
        end
        if (q.size() > 0) shown = q[0];
        @(posedge clk);
        #1;
        flush = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            ifc32.in_valid  = 1'($urandom);
            ifc32.A_in      = $urandom;
            ifc32.B_in      = $urandom;
            ifc32.A_S_in    = 1'($urandom);
            ifc32.tag_in    = 4'($urandom);
            ifc32.out_ready = 1'($urandom);
            ifc64.in_valid  = 1'($urandom);
            ifc64.A_in      = {$urandom, $urandom};
            ifc64.B_in      = {$urandom, $urandom};
            ifc64.A_S_in    = 1'($urandom);
            ifc64.tag_in    = 1'($urandom);
            ifc64.out_ready = 1'($urandom);
            @(posedge clk);
            #1;
            checks++;
            if (dut_view() !== {1'b0, 1'b1, 69'd0}) begin
                errors++;
                $display("[TB] FAIL reset32_c%0d: got %h expected %h", c, dut_view(), {1'b0, 1'b1, 69'd0});
            end
            checks++;
            if ({ifc64.out_valid, ifc64.in_ready, ifc64.A_out, ifc64.B_out, ifc64.A_S_out, ifc64.tag_out}
                !== {1'b0, 1'b1, 130'd0}) begin
                errors++;
                $display("[TB] FAIL reset64_c%0d: valid=%b ready=%b A=%h B=%h expected valid=0 ready=1 zeros",
                         c, ifc64.out_valid, ifc64.in_ready, ifc64.A_out, ifc64.B_out);
            end
        end
        reset = 1'b0;
        q.delete();
        shown = '0;
        ifc32.in_valid = 1'b0;
        ifc64.in_valid = 1'b0;
        ifc64.out_ready = 1'b0;
    endtask

    task automatic test_streaming();
        op32_t op;
        for (int i = 0; i < 8; i++) begin
            op = '{a: 32'h3F800000 + 32'(i), b: 32'h40000000, sub: i[0], tag: i[3:0]};
            applyStimulus(1'b1, op, 1'b1, 1'b0);
            checks++;
            if (dut_view() !== model_view()) begin
                errors++;
                $display("[TB] FAIL stream_model_%0d: got %h expected %h", i, dut_view(), model_view());
            end
            checks++;
            if ({ifc32.out_valid, ifc32.tag_out, ifc32.A_out} !== {1'b1, i[3:0], 32'h3F800000 + 32'(i)}) begin
                errors++;
                $display("[TB] FAIL stream_order_%0d: valid=%b tag=%0d A=%h expected valid=1 tag=%0d A=%h",
                         i, ifc32.out_valid, ifc32.tag_out, ifc32.A_out, i, 32'h3F800000 + 32'(i));
            end
        end
        applyStimulus(1'b0, rand_op(4'd0), 1'b1, 1'b0);
        checks++;
        if (ifc32.out_valid !== 1'b0 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL stream_drain: got %h expected %h", dut_view(), model_view());
        end
    endtask

    task automatic test_backpressure();
        int emitted[$];
        int idx;
        bit ordy;
        bit iv;
        op32_t ops[3];
        for (int k = 0; k < 3; k++) ops[k] = rand_op(4'(k + 1));
        idx = 0;
        for (int cyc = 0; cyc < 20 && emitted.size() < 3; cyc++) begin
            ordy = (cyc >= 3);
            iv = (idx < 3);
            if (ifc32.out_valid && ordy) emitted.push_back(int'(ifc32.tag_out));
            if (iv && ifc32.in_ready) begin
                applyStimulus(1'b1, ops[idx], ordy, 1'b0);
                idx++;
            end else begin
                applyStimulus(iv, ops[(idx < 3) ? idx : 2], ordy, 1'b0);
            end
            checks++;
            if (dut_view() !== model_view()) begin
                errors++;
                $display("[TB] FAIL bp_model_c%0d: got %h expected %h", cyc, dut_view(), model_view());
            end
            if (cyc == 2) begin
                checks++;
                if ({ifc32.in_ready, ifc32.out_valid, ifc32.tag_out} !== {1'b0, 1'b1, 4'd1}) begin
                    errors++;
                    $display("[TB] FAIL bp_full: ready=%b valid=%b tag=%0d expected ready=0 valid=1 tag=1",
                             ifc32.in_ready, ifc32.out_valid, ifc32.tag_out);
                end
            end
        end
        checks++;
        if (emitted.size() != 3) begin
            errors++;
            $display("[TB] FAIL bp_count: got %0d ops out expected 3 (cycle budget)", emitted.size());
        end else begin
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (emitted[k] != k + 1) begin
                    errors++;
                    $display("[TB] FAIL bp_order_%0d: got tag %0d expected %0d", k, emitted[k], k + 1);
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        applyStimulus(1'b1, rand_op(4'd5), 1'b0, 1'b0);
        applyStimulus(1'b1, rand_op(4'd6), 1'b1, 1'b0);
        checks++;
        if ({ifc32.out_valid, ifc32.in_ready, ifc32.tag_out} !== {1'b1, 1'b1, 4'd6}) begin
            errors++;
            $display("[TB] FAIL simul_busy: valid=%b ready=%b tag=%0d expected valid=1 ready=1 tag=6",
                     ifc32.out_valid, ifc32.in_ready, ifc32.tag_out);
        end
        checks++;
        if (dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL simul_model: got %h expected %h", dut_view(), model_view());
        end
        applyStimulus(1'b0, rand_op(4'd0), 1'b1, 1'b0);
        checks++;
        if (dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL simul_drain: got %h expected %h", dut_view(), model_view());
        end
    endtask

    task automatic test_flush();
        applyStimulus(1'b1, rand_op(4'd7), 1'b0, 1'b0);
        applyStimulus(1'b1, rand_op(4'd8), 1'b0, 1'b0);
        checks++;
        if ({ifc32.in_ready, ifc32.tag_out} !== {1'b0, 4'd7}) begin
            errors++;
            $display("[TB] FAIL flush_fill: ready=%b tag=%0d expected ready=0 tag=7", ifc32.in_ready, ifc32.tag_out);
        end
        applyStimulus(1'b1, rand_op(4'd10), 1'b1, 1'b1);
        checks++;
        if ({ifc32.out_valid, ifc32.in_ready} !== 2'b01 || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL flush_empty: got %h expected %h", dut_view(), model_view());
        end
        applyStimulus(1'b1, rand_op(4'd9), 1'b1, 1'b0);
        checks++;
        if ({ifc32.out_valid, ifc32.tag_out} !== {1'b1, 4'd9} || dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL flush_fresh: got %h expected %h", dut_view(), model_view());
        end
        applyStimulus(1'b0, rand_op(4'd0), 1'b1, 1'b0);
        checks++;
        if (dut_view() !== model_view()) begin
            errors++;
            $display("[TB] FAIL flush_drain: got %h expected %h", dut_view(), model_view());
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            applyStimulus($urandom_range(0, 3) != 0, rand_op(4'($urandom)),
                          $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0);
            checks++;
            if (dut_view() !== model_view()) begin
                errors++;
                $display("[TB] FAIL random_c%0d: got %h expected %h", c, dut_view(), model_view());
            end
        end
        applyStimulus(1'b0, rand_op(4'd0), 1'b1, 1'b1);
    endtask

    task automatic test_wide();
        logic [63:0] a_exp;
        logic [63:0] b_exp;
        for (int i = 0; i < 8; i++) begin
            a_exp = 64'h3FF0000000000000 + 64'(i);
            b_exp = {$urandom, $urandom};
            ifc64.in_valid  = 1'b1;
            ifc64.A_in      = a_exp;
            ifc64.B_in      = b_exp;
            ifc64.A_S_in    = i[0];
            ifc64.tag_in    = i[0];
            ifc64.out_ready = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if ({ifc64.out_valid, ifc64.in_ready, ifc64.A_out, ifc64.B_out, ifc64.A_S_out, ifc64.tag_out}
                !== {1'b1, 1'b1, a_exp, b_exp, i[0], i[0]}) begin
                errors++;
                $display("[TB] FAIL wide_%0d: valid=%b ready=%b A=%h B=%h tag=%b expected A=%h B=%h tag=%b",
                         i, ifc64.out_valid, ifc64.in_ready, ifc64.A_out, ifc64.B_out, ifc64.tag_out,
                         a_exp, b_exp, i[0]);
            end
        end
        ifc64.in_valid = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({ifc64.out_valid, ifc64.in_ready, ifc64.A_out} !== {1'b0, 1'b1, 64'h3FF0000000000007}) begin
            errors++;
            $display("[TB] FAIL wide_drain: valid=%b ready=%b A=%h expected valid=0 ready=1 A=3ff0000000000007",
                     ifc64.out_valid, ifc64.in_ready, ifc64.A_out);
        end
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        shown = '0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_flush();
        test_random();
        test_wide();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
